// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Default widths match the 20-bit BCD input of the display driver.
package bin2bcd_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    localparam int DEF_BIN_W  = 16;
    localparam int DEF_DIGITS = 5;
    localparam int DEF_BCD_W  = 4 * DEF_DIGITS;

endpackage

// File: rtl/bin2bcd_conv_add3.sv
// Double-dabble digit cell: adds 3 to a BCD digit of 5 or more.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= BCD_ADJ_THRESH) ? d + BCD_ADJ_ADD : d;

endmodule

// File: rtl/bin2bcd_conv.sv
// Sequential double-dabble converter, one shift-and-adjust step per clock.
// bcd only updates on the final step so the display never sees partial digits.
module bin2bcd_conv
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS,
    parameter int AUTO   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   sh;
    logic [BIN_W-1:0]   last_bin;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   scratch_nxt;
    logic               launch;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .d (scratch[4*g +: 4]),
            .q (adj[4*g +: 4])
        );
    end

    assign scratch_nxt = {adj[BCD_W-2:0], sh[BIN_W-1]};

    // In AUTO mode start is ignored; a new operand value is the trigger.
    assign launch = (AUTO != 0) ? (bin != last_bin) : start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '0;
            scratch  <= '0;
            last_bin <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            bcd      <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        sh       <= bin;
                        scratch  <= '0;
                        cnt      <= '0;
                        last_bin <= bin;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    sh      <= {sh[BIN_W-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bcd   <= scratch_nxt;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Scoreboard bench for bin2bcd_conv: manual-start and AUTO instances.
// Inputs change and outputs are sampled on the falling edge.
module tb_bin2bcd_conv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        valid;
    logic [19:0] bcd;

    logic        a_start;
    logic [15:0] a_bin;
    logic        a_busy;
    logic        a_valid;
    logic [19:0] a_bcd;

    int checks = 0;
    int failures = 0;

    logic [19:0] sb[$];
    logic [19:0] a_sb[$];

    always #5 clk = ~clk;

    bin2bcd_conv #(.BIN_W(16), .DIGITS(5), .AUTO(0)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .valid (valid),
        .bcd   (bcd)
    );

    bin2bcd_conv #(.BIN_W(16), .DIGITS(5), .AUTO(1)) dut_auto (
        .clk   (clk),
        .reset (reset),
        .start (a_start),
        .bin   (a_bin),
        .busy  (a_busy),
        .valid (a_valid),
        .bcd   (a_bcd)
    );

    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Drives start for one edge; returns at the falling edge after acceptance.
    task automatic launch_conv(input logic [15:0] v);
        bin   = v;
        start = 1'b1;
        sb.push_back(ref_bcd(int'(v)));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for valid; counts busy cycles seen on the way.
    task automatic wait_valid(output bit got, output int nbusy);
        got = 0;
        nbusy = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (valid) got = 1;
            else begin
                if (busy) nbusy++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        start   = 1'b0;
        bin     = '0;
        a_start = 1'b1;
        a_bin   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, valid, bcd} !== 22'd0) begin
            failures++;
            $display("FAIL reset_state got busy=%b valid=%b bcd=%h want 0/0/00000",
                     busy, valid, bcd);
        end
        checks++;
        if ({a_busy, a_valid, a_bcd} !== 22'd0) begin
            failures++;
            $display("FAIL reset_state_auto got busy=%b valid=%b bcd=%h want 0/0/00000",
                     a_busy, a_valid, a_bcd);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit got;
        int nbusy;
        logic [19:0] exp;
        launch_conv(16'd1234);
        wait_valid(got, nbusy);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL basic_timeout got no valid want valid within 40 cycles");
        end
        exp = sb.pop_front();
        checks++;
        if (nbusy !== 16) begin
            failures++;
            $display("FAIL basic_busy_cycles got %0d want 16", nbusy);
        end
        checks++;
        if (bcd !== exp || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_result got bcd=%h busy=%b want bcd=%h busy=0",
                     bcd, busy, exp);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_valid_pulse got valid=%b want 0", valid);
        end
    endtask

    task automatic test_edges;
        logic [15:0] vals [3];
        bit got;
        int nbusy;
        logic [19:0] exp;
        vals[0] = 16'd0;
        vals[1] = 16'd65535;
        vals[2] = 16'd12345;
        for (int k = 0; k < 3; k++) begin
            launch_conv(vals[k]);
            wait_valid(got, nbusy);
            exp = sb.pop_front();
            checks++;
            if (!got || bcd !== exp) begin
                failures++;
                $display("FAIL edge_%0d got valid=%b bcd=%h want valid=1 bcd=%h",
                         vals[k], got, bcd, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignored_start;
        int nvalid;
        logic [19:0] exp;
        logic [19:0] seen;
        nvalid = 0;
        seen = '0;
        launch_conv(16'd4321);
        for (int i = 1; i < 40; i++) begin
            if (i == 5) begin
                bin = 16'd1111;
                start = 1'b1;
            end else start = 1'b0;
            if (valid) begin
                nvalid++;
                seen = bcd;
            end
            @(negedge clk);
        end
        start = 1'b0;
        exp = sb.pop_front();
        checks++;
        if (nvalid !== 1 || seen !== exp) begin
            failures++;
            $display("FAIL ignored_start got %0d valids bcd=%h want 1 valid bcd=%h",
                     nvalid, seen, exp);
        end
    endtask

    task automatic test_back_to_back;
        bit got;
        int nbusy;
        logic [19:0] exp;
        launch_conv(16'd2468);
        wait_valid(got, nbusy);
        exp = sb.pop_front();
        checks++;
        if (!got || bcd !== exp) begin
            failures++;
            $display("FAIL b2b_first got bcd=%h want %h", bcd, exp);
        end
        launch_conv(16'd9999);
        wait_valid(got, nbusy);
        exp = sb.pop_front();
        checks++;
        if (!got || nbusy !== 16 || bcd !== exp) begin
            failures++;
            $display("FAIL b2b_second got valid=%b busy_cycles=%0d bcd=%h want 1/16/%h",
                     got, nbusy, bcd, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit got;
        int nbusy;
        logic [19:0] exp;
        launch_conv(16'd777);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        checks++;
        if ({busy, valid, bcd} !== 22'd0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b valid=%b bcd=%h want 0/0/00000",
                     busy, valid, bcd);
        end
        launch_conv(16'd42);
        wait_valid(got, nbusy);
        exp = sb.pop_front();
        checks++;
        if (!got || nbusy !== 16 || bcd !== exp) begin
            failures++;
            $display("FAIL reset_recover got valid=%b busy_cycles=%0d bcd=%h want 1/16/%h",
                     got, nbusy, bcd, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_auto;
        int nvalid;
        int nbusy;
        int nbad;
        logic [19:0] exp;
        a_bin = 16'd500;
        a_sb.push_back(ref_bcd(500));
        nvalid = 0;
        nbusy = 0;
        nbad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_busy) nbusy++;
            if (a_valid) begin
                nvalid++;
                exp = (a_sb.size() != 0) ? a_sb.pop_front() : 20'hFFFFF;
                if (a_bcd !== exp) nbad++;
            end
        end
        checks++;
        if (nvalid !== 1 || nbusy !== 16 || nbad !== 0 || a_bcd !== 20'h00500) begin
            failures++;
            $display("FAIL auto_launch got valids=%0d busy=%0d bcd=%h want 1/16/00500",
                     nvalid, nbusy, a_bcd);
        end
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_valid) nvalid++;
        end
        checks++;
        if (nvalid !== 0) begin
            failures++;
            $display("FAIL auto_hold got %0d valids want 0", nvalid);
        end
        a_bin = 16'd123;
        a_sb.push_back(ref_bcd(123));
        a_sb.push_back(ref_bcd(321));
        nvalid = 0;
        nbad = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 3) a_bin = 16'd321;
            if (a_valid) begin
                nvalid++;
                exp = (a_sb.size() != 0) ? a_sb.pop_front() : 20'hFFFFF;
                if (a_bcd !== exp) nbad++;
            end
        end
        checks++;
        if (nvalid !== 2 || nbad !== 0 || a_bcd !== 20'h00321) begin
            failures++;
            $display("FAIL auto_midchange got valids=%0d bad=%0d bcd=%h want 2/0/00321",
                     nvalid, nbad, a_bcd);
        end
    endtask

    task automatic test_random;
        logic [19:0] held;
        logic [19:0] exp;
        bit got;
        held = bcd;
        for (int n = 0; n < 200; n++) begin
            launch_conv(16'($urandom_range(0, 65535)));
            bin = 16'($urandom_range(0, 65535));
            got = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                if (valid) got = 1;
                else begin
                    checks++;
                    if (bcd !== held) begin
                        failures++;
                        $display("FAIL rand_stable got bcd=%h want %h", bcd, held);
                    end
                    @(negedge clk);
                end
            end
            exp = (sb.size() != 0) ? sb.pop_front() : 20'hFFFFF;
            checks++;
            if (!got || bcd !== exp) begin
                failures++;
                $display("FAIL rand_%0d got valid=%b bcd=%h want valid=1 bcd=%h",
                         n, got, bcd, exp);
            end
            held = exp;
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_edges;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid;
        test_auto;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin2bcd_conv.md
# bin2bcd_conv

Sequential double-dabble converter that turns a binary value from the processor datapath (register/ALU result, 16 bits) into packed BCD digits for the 7-segment display driver. It sits directly upstream of the display driver, and its `bcd` output connects straight to the driver's 20-bit BCD input `x`. One shift-and-adjust step is performed per clock, behind a start/busy/valid handshake. The last result is held stable between conversions so the display never shows partial values.

## Interface
- `BIN_W`, default 16: binary input width.
- `DIGITS`, default 5: BCD digits produced. Legal only when 10^DIGITS > 2^BIN_W − 1.
- `AUTO`, default 0: 1 = convert automatically whenever `bin` changes, and `start` is ignored.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a conversion of `bin`. Sampled only in IDLE.
- `bin` in BIN_W: unsigned binary operand, captured on the accepting edge.
- `busy` out 1: high while a conversion is in progress.
- `valid` out 1: one-cycle pulse when `bcd` has just been updated.
- `bcd` out 4*DIGITS: packed BCD result. Digit 0 is in [3:0] and the most significant digit is at the top.

## Operation
- Reset values: `busy`=0, `valid`=0, `bcd`=0; state IDLE, counter 0, `last_bin`=0.
- States: IDLE and SHIFT.
- IDLE → SHIFT when (AUTO=0 and `start`=1) or (AUTO=1 and `bin` ≠ `last_bin`). On that edge:
  - load shift register ← `bin` and scratch ← 0;
  - counter ← 0, `last_bin` ← `bin`, `busy` ← 1.
- Each SHIFT edge:
  - every scratch digit ≥ 5 gets +3 (4-bit add, no carry out of the digit);
  - then {scratch, shift} is shifted left by 1 and the counter increments.
- On the SHIFT edge where counter = BIN_W−1:
  - `bcd` ← post-shift scratch, `valid` ← 1, `busy` ← 0, state ← IDLE.
- `valid` is cleared on every other edge, so it is never high for two consecutive cycles.
- `start` while busy is ignored: not queued, and no error.
- `bin` changes during SHIFT do not affect the conversion in flight.
  - In AUTO mode, a value that differs from `last_bin` launches a new conversion when the block is next in IDLE.
- `bcd` holds its value from one `valid` pulse until the next; it never exposes intermediate scratch values.
- Reset mid-conversion aborts immediately: all reset values apply, and the next conversion starts cleanly.
- Widths:
  - counter is clog2(BIN_W) bits;
  - scratch is 4*DIGITS bits;
  - the adjust is applied to all DIGITS digits, including the top digit.

## Timing
- Latency: start accepted at edge E0; shifts occur at E1…E_BIN_W; `valid` and the new `bcd` are visible in the cycle after E_BIN_W.
  - That is 16 cycles for the defaults.
- Throughput: one result per BIN_W+1 cycles at best.
  - IDLE occupies the cycle in which `valid` is high.
  - A `start` asserted during that `valid` cycle is accepted, so back-to-back conversions are legal.
- `busy` rises on E0 and falls on E_BIN_W, the same edge that raises `valid`.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Shared package `bin2bcd_pkg` contains:
  - state typedef {IDLE, SHIFT};
  - `BCD_ADJ_THRESH` = 5 and `BCD_ADJ_ADD` = 3;
  - default width constants, shared with the display driver's 20-bit input.
- One natural sub-module, `bcd_add3`:
  - combinational 4-bit cell: out = in ≥ 5 ? in+3 : in;
  - instantiated DIGITS times in a generate loop.
- The top level holds the FSM, counter, shift/scratch registers, output registers and AUTO change detection.

## Test plan
- **Basic conversion:** AUTO=0, `bin`=16'd1234, `start` pulsed → `busy` high for 16 cycles, then `valid` pulse with `bcd`=20'h01234.
- **Edge values:**
  - `bin`=0 → `bcd`=20'h00000;
  - `bin`=65535 → `bcd`=20'h65535;
  - `bin`=12345 → `bcd`=20'h12345.
- **Ignored and back-to-back starts:**
  - `start` re-pulsed at cycle 5 of a conversion → ignored; exactly one `valid`, with the original result.
  - `start` held during the `valid` cycle with `bin`=9999 → second `valid` 16 cycles later with `bcd`=20'h09999.
- **Reset mid-conversion:** `reset` at cycle 8 → next cycle shows `busy`=0, `valid`=0, `bcd`=0; a fresh conversion of 42 then yields 20'h00042.
- **AUTO mode:**
  - `bin` steps 0 → 500 → conversion launches without `start`, giving `bcd`=20'h00500;
  - `bin` held at 500 → no further `valid`;
  - `bin` changed mid-conversion → a second conversion follows.
- **Randomized self-check:** 200 random `bin` values, each checked against a reference computed by decimal digit extraction; `bcd` checked stable between `valid` pulses.
